conv_pe_row: RTL and testbench

//  Parametrised row-convolution processing element: holds TAPS signed weights and a sliding window of TAPS

---
 rtl/conv_pe_row.sv | 193 +++++++++++++++++++
 tb/tb_conv_pe_row.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_row.sv
// Row-convolution PE: TAPS signed weights against a sliding feature window, plus incoming psum.
// Two-stage valid/ready pipeline with saturating result; rows chain vertically into KxK kernels.
module conv_pe_row #(
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned INTERNAL_BITS = 32,
    parameter int unsigned TAPS          = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     w_load,
    input  logic [DATA_BITS-1:0]     w_in,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [DATA_BITS-1:0]     if_in,
    input  logic [INTERNAL_BITS-1:0] psum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INTERNAL_BITS-1:0] result,
    output logic                     sat_flag,
    output logic                     weights_ok
);

    localparam int unsigned PROD_W  = 2 * DATA_BITS;
    localparam int unsigned CNT_W   = $clog2(TAPS + 1);
    localparam int unsigned SUM_W_A = INTERNAL_BITS + $clog2(TAPS) + 1;
    localparam int unsigned SUM_W_B = PROD_W + $clog2(TAPS) + 1;
    localparam int unsigned SUM_W   = (SUM_W_A > SUM_W_B) ? SUM_W_A : SUM_W_B;
    localparam int unsigned UP_W    = SUM_W - INTERNAL_BITS + 1;

    typedef enum logic [1:0] {
        W_LOAD = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                          state_q;
    logic [CNT_W-1:0]                w_cnt_q;
    logic [CNT_W-1:0]                fill_cnt_q;
    logic signed [DATA_BITS-1:0]     w_q    [TAPS];
    logic signed [DATA_BITS-1:0]     f_q    [TAPS];
    logic signed [DATA_BITS-1:0]     win_c  [TAPS];
    logic signed [PROD_W-1:0]        prod_c [TAPS];
    logic signed [PROD_W-1:0]        prod_q [TAPS];
    logic signed [INTERNAL_BITS-1:0] psum_q;
    logic                            v1_q;
    logic                            out_valid_q;
    logic [INTERNAL_BITS-1:0]        result_q;
    logic                            sat_q;

    logic                            en_c;
    logic                            hs_c;
    logic                            issue_c;
    logic signed [SUM_W-1:0]         sum_c;
    logic [UP_W-1:0]                 upper_c;
    logic                            ovf_c;
    logic [INTERNAL_BITS-1:0]        sat_val_c;

    // Flow control: a stalled output freezes both stages and the input.
    always_comb begin
        en_c     = !out_valid_q || out_ready;
        if_ready = (state_q != W_LOAD) && en_c && !w_load && !clear;
        hs_c     = if_valid && if_ready;
        issue_c  = hs_c && ((state_q == RUN) ||
                            ((state_q == FILL) && (fill_cnt_q == CNT_W'(TAPS - 1))));
    end

    // Window as it will look after the incoming beat shifts in at index 0.
    always_comb begin
        win_c[0] = $signed(if_in);
        for (int i = 1; i < int'(TAPS); i++) begin
            win_c[i] = f_q[i-1];
        end
        for (int i = 0; i < int'(TAPS); i++) begin
            prod_c[i] = PROD_W'(w_q[i]) * PROD_W'(win_c[i]);
        end
    end

    // Wide accumulate, then clamp when the bits above the result width disagree with its sign.
    always_comb begin
        sum_c = SUM_W'(psum_q);
        for (int i = 0; i < int'(TAPS); i++) begin
            sum_c = sum_c + SUM_W'(prod_q[i]);
        end
        upper_c = sum_c[SUM_W-1:INTERNAL_BITS-1];
        ovf_c   = !((&upper_c) || !(|upper_c));
        if (!ovf_c) begin
            sat_val_c = sum_c[INTERNAL_BITS-1:0];
        end else if (sum_c[SUM_W-1]) begin
            sat_val_c = {1'b1, {(INTERNAL_BITS-1){1'b0}}};
        end else begin
            sat_val_c = {1'b0, {(INTERNAL_BITS-1){1'b1}}};
        end
    end

    // Later assignments take priority: clear overrides the pipeline, a mid-run w_load overrides clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= W_LOAD;
            w_cnt_q     <= '0;
            fill_cnt_q  <= '0;
            psum_q      <= '0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                w_q[i]    <= '0;
                f_q[i]    <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            if (en_c) begin
                for (int i = 0; i < int'(TAPS); i++) begin
                    prod_q[i] <= prod_c[i];
                end
                psum_q      <= $signed(psum_in);
                v1_q        <= issue_c;
                result_q    <= sat_val_c;
                out_valid_q <= v1_q;
                if (v1_q && ovf_c) begin
                    sat_q <= 1'b1;
                end
            end

            if (hs_c) begin
                f_q[0] <= $signed(if_in);
                for (int i = 1; i < int'(TAPS); i++) begin
                    f_q[i] <= f_q[i-1];
                end
            end

            case (state_q)
                W_LOAD: begin
                    if (w_load) begin
                        w_q[0] <= $signed(w_in);
                        for (int i = 1; i < int'(TAPS); i++) begin
                            w_q[i] <= w_q[i-1];
                        end
                        if (w_cnt_q == CNT_W'(TAPS - 1)) begin
                            state_q    <= FILL;
                            w_cnt_q    <= '0;
                            fill_cnt_q <= '0;
                        end else begin
                            w_cnt_q <= w_cnt_q + CNT_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (issue_c) begin
                        state_q    <= RUN;
                        fill_cnt_q <= '0;
                    end else if (hs_c) begin
                        fill_cnt_q <= fill_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase

            if (clear) begin
                fill_cnt_q  <= '0;
                v1_q        <= 1'b0;
                out_valid_q <= 1'b0;
                sat_q       <= 1'b0;
                for (int i = 0; i < int'(TAPS); i++) begin
                    f_q[i] <= '0;
                end
                if (state_q != W_LOAD) begin
                    state_q <= FILL;
                end
            end

            if (w_load && (state_q != W_LOAD)) begin
                w_q[0] <= $signed(w_in);
                for (int i = 1; i < int'(TAPS); i++) begin
                    w_q[i] <= w_q[i-1];
                end
                state_q     <= W_LOAD;
                w_cnt_q     <= CNT_W'(1);
                fill_cnt_q  <= '0;
                v1_q        <= 1'b0;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign sat_flag   = sat_q;
    assign weights_ok = (state_q != W_LOAD);

endmodule

// File: tb/tb_conv_pe_row.sv
// Bench for conv_pe_row: driver updates a history-based reference model and queues expected
// results; an independent monitor pops and compares on every output handshake.
module tb_conv_pe_row;

    localparam int unsigned DB   = 16;
    localparam int unsigned IB   = 32;
    localparam int unsigned TAPS = 3;
    localparam longint MAXV = (longint'(1) <<< (IB - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (IB - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          w_load = 1'b0;
    logic [DB-1:0] w_in = '0;
    logic          if_valid = 1'b0;
    logic          if_ready;
    logic [DB-1:0] if_in = '0;
    logic [IB-1:0] psum_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IB-1:0] result;
    logic          sat_flag;
    logic          weights_ok;

    conv_pe_row #(.DATA_BITS(DB), .INTERNAL_BITS(IB), .TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .clear(clear), .w_load(w_load), .w_in(w_in),
        .if_valid(if_valid), .if_ready(if_ready), .if_in(if_in), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .sat_flag(sat_flag), .weights_ok(weights_ok)
    );

    always #5 clk = ~clk;

    typedef struct { longint val; bit sat; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: most recent weight/feature first, so index i pairs with index i.
    int   w_hist[$];
    int   f_hist[$];
    int   wcnt;
    int   fcnt;
    bit   loaded;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic exp_t model_eval(input int psum);
        exp_t   e;
        longint s;
        s = longint'(psum);
        for (int i = 0; i < int'(TAPS); i++) s += longint'(w_hist[i]) * longint'(f_hist[i]);
        e.sat = 1'b0;
        if (s > MAXV) begin s = MAXV; e.sat = 1'b1; end
        else if (s < MINV) begin s = MINV; e.sat = 1'b1; end
        e.val = s;
        return e;
    endfunction

    task automatic model_reset();
        w_hist = {};
        f_hist = {};
        for (int i = 0; i < int'(TAPS); i++) begin
            w_hist.push_back(0);
            f_hist.push_back(0);
        end
        wcnt   = 0;
        fcnt   = 0;
        loaded = 1'b0;
        exp_q.delete();
    endtask

    // One clock of stimulus; handshake decided just before the rising edge.
    task automatic cycle(input bit wl, input int w, input bit fv, input int f,
                         input int ps, input bit clr, input bit ordy);
        bit flush;
        bit hs;
        bit exp_rdy;
        w_load = wl; w_in = DB'(w); if_valid = fv; if_in = DB'(f);
        psum_in = IB'(ps); clear = clr; out_ready = ordy;
        @(negedge clk);
        flush   = 1'b0;
        exp_rdy = loaded && !wl && !clr && (!out_valid || ordy);
        if (fv) chk("if_ready", longint'(if_ready), longint'(exp_rdy));
        hs = fv && if_ready;
        if (clr) begin
            fcnt  = 0;
            flush = 1'b1;
        end
        if (wl) begin
            w_hist.push_front(int'($signed(w_in)));
            void'(w_hist.pop_back());
            if (loaded) begin
                loaded = 1'b0; wcnt = 1; fcnt = 0; flush = 1'b1;
            end else begin
                wcnt++;
                if (wcnt == int'(TAPS)) begin
                    loaded = 1'b1; wcnt = 0; fcnt = 0;
                end
            end
        end else if (hs) begin
            f_hist.push_front(int'($signed(if_in)));
            void'(f_hist.pop_back());
            fcnt++;
            if (fcnt >= int'(TAPS)) exp_q.push_back(model_eval(int'($signed(psum_in))));
        end
        @(posedge clk);
        if (flush) exp_q.delete();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    // Monitor: checks every accepted result in order and holds stability while stalled.
    bit            held = 1'b0;
    logic [IB-1:0] held_val = '0;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (held) chk("hold_result", longint'($signed(result)), longint'($signed(held_val)));
            if (out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0d expected no output", $signed(result));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", longint'($signed(result)), mon_e.val);
                    if (mon_e.sat) chk("sat_flag_set", longint'(sat_flag), 1);
                end
            end else begin
                held     = 1'b1;
                held_val = result;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        chk("drain_empty", longint'(exp_q.size()), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_ready", longint'(if_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        chk("rst_weights_ok", longint'(weights_ok), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic 1,2,3 x 4,5,6 window, latency, then one more beat with psum.
        cycle(1'b1, 1, 1'b0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 2, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("wl_partial", longint'(weights_ok), 0);
        cycle(1'b1, 3, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("wl_done", longint'(weights_ok), 1);
        cycle(1'b0, 0, 1'b1, 4, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b1, 5, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b1, 6, 0, 1'b0, 1'b1);
        chk("lat_early", longint'(out_valid), 0);
        idle(1);
        chk("lat_valid", longint'(out_valid), 1);
        chk("first_result", longint'($signed(result)), 32);
        cycle(1'b0, 0, 1'b1, 7, 100, 1'b0, 1'b1);
        idle(3);

        // Backpressure: five stalled cycles with a stream in flight.
        for (int k = 0; k < 10; k++)
            cycle(1'b0, 0, 1'b1, int'($urandom_range(0, 200)) - 100,
                  int'($urandom_range(0, 2000)) - 1000, 1'b0, !(k >= 2 && k < 7));
        drain();

        // Negative saturation, sticky flag, and clear.
        repeat (3) cycle(1'b1, 32767, 1'b0, 0, 0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 0, 1'b1, -32768, 0, 1'b0, 1'b1);
        drain();
        chk("sat_sticky", longint'(sat_flag), 1);
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
        chk("sat_cleared", longint'(sat_flag), 0);
        chk("clear_keeps_weights", longint'(weights_ok), 1);

        // w_load colliding with a feature beat while a result is pending.
        for (int k = 0; k < 5; k++) cycle(1'b0, 0, 1'b1, k + 1, 0, 1'b0, 1'b0);
        chk("pending_valid", longint'(out_valid), 1);
        cycle(1'b1, 5, 1'b1, 9, 0, 1'b0, 1'b0);
        chk("wl_flush_valid", longint'(out_valid), 0);
        chk("wl_state", longint'(weights_ok), 0);
        cycle(1'b1, 6, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("wl_cnt_two", longint'(weights_ok), 0);
        cycle(1'b1, 7, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("wl_cnt_three", longint'(weights_ok), 1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 0, 1'b1, 10 * k - 20, k, 1'b0, 1'b1);
        drain();

        // Random traffic: weights reload, clear, bubbles and stalls.
        for (int k = 0; k < 500; k++) begin
            int ps;
            ps = ($urandom_range(0, 9) == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
            cycle($urandom_range(0, 99) < 3, int'($urandom), $urandom_range(0, 99) < 75,
                  int'($urandom), ps, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80);
        end
        drain();

        // Reset mid-stream.
        if (!loaded) repeat (3) cycle(1'b1, int'($urandom), 1'b0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 0, 1'b1, int'($urandom), 0, 1'b0, 1'b0);
        if_valid = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_result", longint'(result), 0);
        chk("mid_rst_sat_flag", longint'(sat_flag), 0);
        chk("mid_rst_weights_ok", longint'(weights_ok), 0);
        chk("mid_rst_if_ready", longint'(if_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cycle(1'b0, 0, 1'b1, k, 0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b1, int'($urandom), 1'b0, 0, 0, 1'b0, 1'b1);
        chk("reload_weights_ok", longint'(weights_ok), 1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 0, 1'b1, int'($urandom), int'($urandom_range(0, 50)), 1'b0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
